// File: rtl/int_rti_sequencer_if.sv
// Pipeline <-> interrupt/RTI sequencer signal bundle.
// slave = sequencer side, master = pipeline side driving requests and pop data.
interface int_rti_sequencer_if;
    logic        int_req;
    logic        rti_exec;
    logic        stall_hdu;
    logic        flush_branch;
    logic [31:0] pc_decode;
    logic [15:0] pop_data;
    logic        fetch_hold;
    logic        decode_bubble;
    logic        mem_int;
    logic        mem_pop;
    logic [1:0]  mem_counter;
    logic [31:0] save_pc;
    logic        pc_load;
    logic [31:0] pc_load_value;
    logic        ccr_restore;
    logic [2:0]  ccr_value;
    logic        int_ack;

    modport slave (
        input  int_req, rti_exec, stall_hdu, flush_branch, pc_decode, pop_data,
        output fetch_hold, decode_bubble, mem_int, mem_pop, mem_counter, save_pc,
               pc_load, pc_load_value, ccr_restore, ccr_value, int_ack
    );

    modport master (
        output int_req, rti_exec, stall_hdu, flush_branch, pc_decode, pop_data,
        input  fetch_hold, decode_bubble, mem_int, mem_pop, mem_counter, save_pc,
               pc_load, pc_load_value, ccr_restore, ccr_value, int_ack
    );
endinterface

// File: rtl/int_rti_sequencer.sv
// Interrupt entry (drain, push PC/CCR, vector) and RTI return (pop, resume) sequencer.
// Entry: int_req edge to pc_load in DRAIN_CYCLES+6 cycles; stall/flush defer entry, all outputs registered.
module int_rti_sequencer #(
    parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0000,
    parameter int          DRAIN_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    int_rti_sequencer_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_DRAIN, S_PUSH, S_VECTOR, S_POP, S_POP_WAIT, S_RESUME
    } state_t;

    localparam int            CW         = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] DRAIN_LAST = CW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    state_t      r_state;
    logic        r_int_sync, r_int_prev, r_pending;
    logic [CW-1:0] r_drain_cnt;
    logic        r_fetch_hold, r_decode_bubble, r_mem_int, r_mem_pop;
    logic [1:0]  r_mem_counter;
    logic [31:0] r_save_pc, r_pc_load_value;
    logic        r_pc_load, r_ccr_restore, r_int_ack;
    logic [2:0]  r_ccr_value;
    logic        w_int_edge;

    assign w_int_edge = r_int_sync & ~r_int_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_int_sync      <= 1'b0;
            r_int_prev      <= 1'b0;
            r_pending       <= 1'b0;
            r_drain_cnt     <= '0;
            r_fetch_hold    <= 1'b0;
            r_decode_bubble <= 1'b0;
            r_mem_int       <= 1'b0;
            r_mem_pop       <= 1'b0;
            r_mem_counter   <= 2'd0;
            r_save_pc       <= 32'd0;
            r_pc_load       <= 1'b0;
            r_pc_load_value <= 32'd0;
            r_ccr_restore   <= 1'b0;
            r_ccr_value     <= 3'd0;
            r_int_ack       <= 1'b0;
        end else begin
            r_int_sync    <= bus.int_req;
            r_int_prev    <= r_int_sync;
            r_pc_load     <= 1'b0;
            r_ccr_restore <= 1'b0;
            r_int_ack     <= 1'b0;
            // One-deep pending: further edges while set simply merge.
            if (w_int_edge)
                r_pending <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (bus.rti_exec) begin
                        r_state         <= S_POP;
                        r_fetch_hold    <= 1'b1;
                        r_decode_bubble <= 1'b1;
                        r_mem_pop       <= 1'b1;
                        r_mem_counter   <= 2'd2;
                    end else if (r_pending && !bus.stall_hdu && !bus.flush_branch) begin
                        r_save_pc       <= bus.pc_decode;
                        r_fetch_hold    <= 1'b1;
                        r_decode_bubble <= 1'b1;
                        r_drain_cnt     <= '0;
                        if (DRAIN_CYCLES > 0) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_state       <= S_PUSH;
                            r_mem_int     <= 1'b1;
                            r_mem_counter <= 2'd0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == DRAIN_LAST) begin
                        r_state       <= S_PUSH;
                        r_mem_int     <= 1'b1;
                        r_mem_counter <= 2'd0;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                S_PUSH: begin
                    if (r_mem_counter == 2'd2) begin
                        r_state         <= S_VECTOR;
                        r_mem_int       <= 1'b0;
                        r_mem_counter   <= 2'd0;
                        r_fetch_hold    <= 1'b0;
                        r_pc_load       <= 1'b1;
                        r_pc_load_value <= VECTOR_ADDR;
                        r_int_ack       <= 1'b1;
                    end else begin
                        r_mem_counter <= r_mem_counter + 2'd1;
                    end
                end
                S_VECTOR: begin
                    r_state         <= S_IDLE;
                    r_decode_bubble <= 1'b0;
                    r_pending       <= w_int_edge;
                end
                S_POP: begin
                    // Read data trails each pop step by one cycle.
                    if (r_mem_counter == 2'd1)
                        r_ccr_value <= bus.pop_data[2:0];
                    if (r_mem_counter == 2'd0) begin
                        r_save_pc[15:0] <= bus.pop_data;
                        r_mem_pop       <= 1'b0;
                        r_state         <= S_POP_WAIT;
                    end else begin
                        r_mem_counter <= r_mem_counter - 2'd1;
                    end
                end
                S_POP_WAIT: begin
                    r_save_pc[31:16] <= bus.pop_data;
                    r_pc_load_value  <= {bus.pop_data, r_save_pc[15:0]};
                    r_pc_load        <= 1'b1;
                    r_ccr_restore    <= 1'b1;
                    r_fetch_hold     <= 1'b0;
                    r_state          <= S_RESUME;
                end
                S_RESUME: begin
                    r_state         <= S_IDLE;
                    r_decode_bubble <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.fetch_hold    = r_fetch_hold;
    assign bus.decode_bubble = r_decode_bubble;
    assign bus.mem_int       = r_mem_int;
    assign bus.mem_pop       = r_mem_pop;
    assign bus.mem_counter   = r_mem_counter;
    assign bus.save_pc       = r_save_pc;
    assign bus.pc_load       = r_pc_load;
    assign bus.pc_load_value = r_pc_load_value;
    assign bus.ccr_restore   = r_ccr_restore;
    assign bus.ccr_value     = r_ccr_value;
    assign bus.int_ack       = r_int_ack;
endmodule

// File: tb/tb_int_rti_sequencer.sv
// Directed bench for int_rti_sequencer: entry timing, RTI pop/resume, deferral, priority, reset abort.
module tb_int_rti_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic p_pl = 1'b0, p_cr = 1'b0, p_ia = 1'b0;

    int_rti_sequencer_if bus ();

    int_rti_sequencer #(.VECTOR_ADDR(32'h0000_0000), .DRAIN_CYCLES(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {fetch_hold, decode_bubble, mem_int, mem_pop, mem_counter, pc_load, ccr_restore, int_ack, ccr_value}
    function automatic logic [11:0] ctl();
        return {bus.fetch_hold, bus.decode_bubble, bus.mem_int, bus.mem_pop, bus.mem_counter,
                bus.pc_load, bus.ccr_restore, bus.int_ack, bus.ccr_value};
    endfunction

    always @(negedge clk) begin
        chk("mem_excl", {31'd0, bus.mem_int & bus.mem_pop}, 32'd0);
        chk("strobe_width", {29'd0, p_pl & bus.pc_load, p_cr & bus.ccr_restore, p_ia & bus.int_ack}, 32'd0);
        p_pl = bus.pc_load;
        p_cr = bus.ccr_restore;
        p_ia = bus.int_ack;
    end

    task automatic do_rti(input logic [2:0] prev_ccr, input logic [15:0] d0,
                          input logic [15:0] d1, input logic [15:0] d2);
        logic [11:0] c;
        c = {9'd0, d0[2:0]};
        bus.rti_exec = 1'b1;
        tick();
        bus.rti_exec = 1'b0;
        chk("rti_pop2", ctl(), 12'hD80 | {9'd0, prev_ccr});
        tick();
        chk("rti_pop1", ctl(), 12'hD40 | {9'd0, prev_ccr});
        bus.pop_data = d0;
        tick();
        chk("rti_pop0", ctl(), 12'hD00 | c);
        bus.pop_data = d1;
        tick();
        chk("rti_popwait", ctl(), 12'hC00 | c);
        bus.pop_data = d2;
        tick();
        chk("rti_resume", ctl(), 12'h430 | c);
        chk("rti_pc_value", bus.pc_load_value, {d2, d1});
        tick();
        chk("rti_idle", ctl(), c);
        chk("rti_save_pc", bus.save_pc, {d2, d1});
    endtask

    task automatic defer_test(input logic use_flush, input int n, input logic [31:0] pc_final);
        bus.stall_hdu    = ~use_flush;
        bus.flush_branch = use_flush;
        bus.pc_decode    = 32'h0000_0100;
        bus.int_req      = 1'b1;
        tick();
        tick();
        for (int i = 0; i < n; i++) begin
            chk("defer_idle", {31'd0, bus.fetch_hold}, 32'd0);
            bus.pc_decode = 32'h0000_0100 + i;
            tick();
        end
        bus.stall_hdu    = 1'b0;
        bus.flush_branch = 1'b0;
        bus.pc_decode    = pc_final;
        chk("defer_still_idle", {31'd0, bus.fetch_hold}, 32'd0);
        tick();
        chk("defer_drain", {31'd0, bus.fetch_hold}, 32'd1);
        chk("defer_save_pc", bus.save_pc, pc_final);
        bus.pc_decode = 32'hDEAD_0000;
        for (int i = 0; i < 5; i++) tick();
        chk("defer_no_early_load", {31'd0, bus.pc_load}, 32'd0);
        tick();
        chk("defer_vector", {30'd0, bus.pc_load, bus.int_ack}, 32'd3);
        chk("defer_save_pc_hold", bus.save_pc, pc_final);
        bus.int_req = 1'b0;
        tick();
        tick();
    endtask

    logic [11:0] t1_exp [10] = '{12'h000, 12'h000, 12'hC00, 12'hC00, 12'hC00,
                                 12'hE00, 12'hE40, 12'hE80, 12'h428, 12'h000};

    initial begin
        reset            = 1'b1;
        bus.int_req      = 1'b0;
        bus.rti_exec     = 1'b0;
        bus.stall_hdu    = 1'b0;
        bus.flush_branch = 1'b0;
        bus.pc_decode    = 32'd0;
        bus.pop_data     = 16'd0;
        tick();
        tick();
        chk("reset_ctl", ctl(), 12'h000);
        chk("reset_save_pc", bus.save_pc, 32'd0);
        chk("reset_pc_value", bus.pc_load_value, 32'd0);
        reset = 1'b0;
        tick();

        // Interrupt entry; rti_exec held during DRAIN/PUSH must be ignored.
        bus.pc_decode = 32'h0000_0040;
        bus.int_req   = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("entry_c%0d", k + 1), ctl(), t1_exp[k]);
            if (k == 2) begin
                chk("entry_latch_pc", bus.save_pc, 32'h0000_0040);
                bus.rti_exec  = 1'b1;
                bus.pc_decode = 32'h0000_0999;
            end
            if (k == 7) bus.rti_exec = 1'b0;
            if (k == 8) begin
                chk("entry_pc_value", bus.pc_load_value, 32'h0000_0000);
                chk("entry_save_pc", bus.save_pc, 32'h0000_0040);
            end
        end
        bus.int_req = 1'b0;
        tick();
        tick();

        do_rti(3'd0, 16'hABCD, 16'h0040, 16'h0000);
        do_rti(3'd5, 16'h0002, 16'h1234, 16'h8765);

        defer_test(1'b0, 4, 32'h0000_0200);
        defer_test(1'b1, 2, 32'h0000_0280);

        // RTI and pending in the same IDLE cycle: RTI first, then entry.
        bus.pc_decode = 32'h0000_0300;
        bus.int_req   = 1'b1;
        tick();
        tick();
        do_rti(3'd2, 16'h0007, 16'h0044, 16'h0000);
        tick();
        chk("prio_drain", {31'd0, bus.fetch_hold}, 32'd1);
        chk("prio_save_pc", bus.save_pc, 32'h0000_0300);
        for (int i = 0; i < 5; i++) tick();
        chk("prio_no_early_load", {31'd0, bus.pc_load}, 32'd0);
        tick();
        chk("prio_vector", {30'd0, bus.pc_load, bus.int_ack}, 32'd3);
        bus.int_req = 1'b0;
        tick();
        tick();

        // Reset in the second PUSH cycle.
        bus.pc_decode = 32'h0000_0500;
        bus.int_req   = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            if (k == 1) bus.int_req = 1'b0;
        end
        chk("abort_push1", {29'd0, bus.mem_int, bus.mem_counter}, 32'd5);
        reset = 1'b1;
        tick();
        chk("abort_ctl", ctl(), 12'h000);
        chk("abort_save_pc", bus.save_pc, 32'd0);
        chk("abort_pc_value", bus.pc_load_value, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("abort_quiet", {29'd0, bus.pc_load, bus.mem_int, bus.mem_pop}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/int_rti_sequencer.md
INT_RTI_SEQUENCER -- requirements
Module: int_rti_sequencer

Interface
REQ-001 SHALL have parameter VECTOR_ADDR, default 32'h0000_0000, PC loaded on interrupt entry.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3, bubble cycles before first push.
REQ-003 SHALL have port clk, input, 1 bit, single clock, all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1 bit, synchronous, active-high.
REQ-005 SHALL have port int_req, input, 1 bit, external interrupt request level.
REQ-006 SHALL have port rti_exec, input, 1 bit, RTI instruction in execute stage.
REQ-007 SHALL have port stall_hdu, input, 1 bit, hazard-unit stall active.
REQ-008 SHALL have port flush_branch, input, 1 bit, taken branch or jump in execute.
REQ-009 SHALL have port pc_decode, input, 32 bits, PC of instruction in decode.
REQ-010 SHALL have port pop_data, input, 16 bits, memory-stage read data.
REQ-011 SHALL have port fetch_hold, output, 1 bit, freeze PC and fetch/decode register.
REQ-012 SHALL have port decode_bubble, output, 1 bit, force NOP opcode into control-unit mux.
REQ-013 SHALL have port mem_int, output, 1 bit, memory stage performs push of sequencer data.
REQ-014 SHALL have port mem_pop, output, 1 bit, memory stage performs pop.
REQ-015 SHALL have port mem_counter, output, 2 bits, push/pop step: 0 PC[31:16], 1 PC[15:0], 2 CCR.
REQ-016 SHALL have port save_pc, output, 32 bits, latched return address.
REQ-017 SHALL have port pc_load, output, 1 bit, one-cycle PC overwrite strobe.
REQ-018 SHALL have port pc_load_value, output, 32 bits, PC value on pc_load.
REQ-019 SHALL have port ccr_restore, output, 1 bit, one-cycle strobe loading ccr_value into CCR.
REQ-020 SHALL have port ccr_value, output, 3 bits, restored flags.
REQ-021 SHALL have port int_ack, output, 1 bit, one-cycle pulse on vector load.

Function
REQ-022 SHALL register int_req and set one-deep pending flag on 0->1 edge; extra edges while pending set SHALL be dropped.
REQ-023 SHALL implement states IDLE, DRAIN, PUSH, VECTOR, POP, POP_WAIT, RESUME.
REQ-024 IDLE priority: rti_exec -> POP; else pending && !stall_hdu && !flush_branch -> DRAIN, latching save_pc <= pc_decode; else stay.
REQ-025 Pending with stall_hdu or flush_branch SHALL be deferred, not lost.
REQ-026 DRAIN SHALL last exactly DRAIN_CYCLES cycles, fetch_hold=1, decode_bubble=1, then PUSH.
REQ-027 PUSH SHALL last 3 cycles, mem_int=1, mem_counter 0,1,2, fetch_hold=1, decode_bubble=1, then VECTOR.
REQ-028 VECTOR SHALL last 1 cycle: pc_load=1, pc_load_value=VECTOR_ADDR, int_ack=1, pending cleared, fetch_hold=0, then IDLE.
REQ-029 Entry latency: int_req edge to pc_load SHALL be DRAIN_CYCLES+6 cycles when unblocked (1 sync, 1 edge, 1 IDLE decision, DRAIN, 3 PUSH).
REQ-030 POP SHALL last 3 cycles, mem_pop=1, mem_counter 2,1,0, fetch_hold=1, decode_bubble=1; POP_WAIT 1 cycle.
REQ-031 pop_data SHALL be sampled one cycle after each pop step: first -> ccr_value=pop_data[2:0], second -> save_pc[15:0], third (in POP_WAIT) -> save_pc[31:16].
REQ-032 RESUME SHALL last 1 cycle: pc_load=1, pc_load_value=save_pc, ccr_restore=1, then IDLE.
REQ-033 Interrupt edges during POP/POP_WAIT/RESUME SHALL set pending and be serviced from IDLE afterwards.
REQ-034 rti_exec outside IDLE SHALL be ignored.
REQ-035 All strobes (pc_load, ccr_restore, int_ack) SHALL be exactly one cycle wide; mem_int and mem_pop SHALL never be asserted together.

Reset
REQ-036 reset SHALL force IDLE, clear pending, synchronizer and counters, drive every output to 0 including save_pc and ccr_value, on the next rising edge from any state.
REQ-037 reset mid-sequence SHALL abort without further pc_load, mem_int or mem_pop.

Verification
REQ-038 int_req 0->1, pc_decode=32'h0000_0040, no stalls -> mem_counter 0,1,2 with mem_int, then pc_load=1, pc_load_value=0, int_ack, save_pc=32'h40, 9 cycles after edge.
REQ-039 rti_exec in IDLE, pop_data 3'b101, 16'h0040, 16'h0000 -> ccr_value=3'b101, RESUME pc_load_value=32'h0000_0040, ccr_restore=1.
REQ-040 Pending with stall_hdu=1 for 4 cycles -> DRAIN entered on first cycle stall_hdu=0; pc_decode latched that cycle.
REQ-041 rti_exec and pending same IDLE cycle -> RTI completes first, then interrupt entry without new edge.
REQ-042 reset asserted in second PUSH cycle -> next cycle all outputs 0, state IDLE, no pc_load.
